// File: rtl/flag_event_sender.sv
// Source-side driver for the clkA toggle/ack flag crossing: queues event strobes and issues one flag per ack round trip.
// Optional acknowledge timeout is compiled in with `define FLAG_EVENT_SENDER_TIMEOUT_EN.
module flag_event_sender #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clkA,
    input  logic             rstA,
    input  logic             evt_in,
    input  logic             err_clr,
    input  logic             Busy_clkA,
    output logic             FlagIn_clkA,
    output logic [CNT_W-1:0] pending,
    output logic             idle,
    output logic             overflow,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] pending_r;
    logic [CNT_W-1:0] pending_s;
    logic             flag_r;
    logic             overflow_r;
    logic             dec_s;
    logic             drop_s;
    logic             tmo_hit_s;

    // Next-state logic; IDLE also holds off while a stale Busy is still high.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if ((pending_r != PEND_ZERO) && !Busy_clkA) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!Busy_clkA || tmo_hit_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_ACK;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign dec_s = (state_r == IDLE) && (state_s == ISSUE);

    // Saturating pending counter update; an event arriving at full count with no issue is dropped.
    always_comb begin
        pending_s = pending_r;
        drop_s    = 1'b0;
        if (evt_in && !dec_s) begin
            if (pending_r == PEND_MAX) begin
                drop_s = 1'b1;
            end else begin
                pending_s = pending_r + PEND_ONE;
            end
        end else if (!evt_in && dec_s) begin
            pending_s = pending_r - PEND_ONE;
        end else begin
            pending_s = pending_r;
        end
    end

    // State, pending count and flag registers; the flag is registered from the next state.
    always_ff @(posedge clkA) begin
        if (rstA) begin
            state_r   <= IDLE;
            pending_r <= PEND_ZERO;
            flag_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            flag_r    <= (state_s == ISSUE);
        end
    end

    // Sticky overflow flag; a new drop outranks a simultaneous clear.
    always_ff @(posedge clkA) begin
        if (rstA) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (err_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

`ifdef FLAG_EVENT_SENDER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             timeout_err_r;

    assign tmo_hit_s = (state_r == WAIT_ACK) && Busy_clkA &&
                       (tmo_cnt_r == TMO_W'(TIMEOUT - 1));

    // Busy-high cycle counter, restarted as each flag goes out.
    always_ff @(posedge clkA) begin
        if (rstA) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == ISSUE) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_r == WAIT_ACK) && Busy_clkA) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Sticky timeout flag; the timed-out event is treated as sent.
    always_ff @(posedge clkA) begin
        if (rstA) begin
            timeout_err_r <= 1'b0;
        end else if (tmo_hit_s) begin
            timeout_err_r <= 1'b1;
        end else if (err_clr) begin
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    logic unused_timeout_s;

    assign unused_timeout_s = (TIMEOUT > 32'sd0);
    assign tmo_hit_s        = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    assign FlagIn_clkA = flag_r;
    assign pending     = pending_r;
    assign overflow    = overflow_r;
    assign idle        = (state_r == IDLE) && (pending_r == PEND_ZERO);

endmodule
